vga_pattern_sequencer: RTL



---
 rtl/vga_pattern_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous VGA test-pattern scheduler: host req/ack mode changes and auto cycling, applied at frame boundaries.
// Optional build macro VGA_SEQ_AUTO_EN enables the dwell counter and auto-advance logic.
module vga_pattern_sequencer #(
  parameter int unsigned H_RES        = 1366,
  parameter int unsigned V_RES        = 768,
  parameter int unsigned DWELL_FRAMES = 120,
  parameter int unsigned CHK_SHIFT    = 6
) (
  input  logic        clk_pix,
  input  logic        rst,
  input  logic [11:0] sx,
  input  logic [11:0] sy,
  input  logic        de,
  input  logic        auto_en,
  input  logic        mode_req,
  input  logic [2:0]  mode_sel,
  output logic        mode_ack,
  output logic        mode_busy,
  output logic [2:0]  cur_mode,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b
);

  typedef enum logic [1:0] {RUN, PEND, APPLY} state_t;

  function automatic logic [7:0][11:0] calc_bounds();
    logic [7:0][11:0] b;
    for (int unsigned k = 0; k < 8; k++) b[k] = 12'(k * H_RES / 8);
    return b;
  endfunction

  localparam logic [7:0][11:0] BOUNDS = calc_bounds();

  state_t     state;
  logic [2:0] req_mode;
  logic       bnd;
  logic [2:0] strip;
  logic       border;
  logic [2:0] rgb;

  assign bnd    = (sx == '0) && (sy == 12'(V_RES));
  assign border = (sx == '0) || (sx == 12'(H_RES - 1)) ||
                  (sy == '0) || (sy == 12'(V_RES - 1));

  always_comb begin
    strip = '0;
    for (int unsigned k = 1; k < 8; k++)
      if (sx >= BOUNDS[k]) strip = 3'(k);
  end

  always_comb begin
    rgb = '0;
    case (cur_mode)
      3'd0:    rgb = strip;
      3'd1:    rgb = {3{sx[CHK_SHIFT] ^ sy[CHK_SHIFT]}};
      3'd2:    rgb = sx[9:7];
      3'd3:    rgb = '1;
      3'd5:    rgb = {3{border}};
      default: rgb = '0;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (rst) {vga_r, vga_g, vga_b} <= '0;
    else     {vga_r, vga_g, vga_b} <= de ? rgb : '0;
  end

`ifdef VGA_SEQ_AUTO_EN
  localparam int unsigned DW = $clog2(DWELL_FRAMES + 1);
  logic [DW-1:0] dwell_cnt;
`else
  logic unused_auto;
  assign unused_auto = auto_en;
`endif

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state     <= RUN;
      req_mode  <= '0;
      cur_mode  <= '0;
      mode_ack  <= 1'b0;
      mode_busy <= 1'b0;
`ifdef VGA_SEQ_AUTO_EN
      dwell_cnt <= '0;
`endif
    end else begin
      mode_ack <= 1'b0;
      unique case (state)
        RUN: begin
          // A request sampled in RUN wins over an auto step on the same boundary.
          if (mode_req) begin
            req_mode  <= mode_sel;
            mode_busy <= 1'b1;
            state     <= PEND;
          end
`ifdef VGA_SEQ_AUTO_EN
          else if (auto_en && bnd) begin
            if (dwell_cnt == DW'(DWELL_FRAMES - 1)) begin
              dwell_cnt <= '0;
              cur_mode  <= (cur_mode >= 3'd5) ? 3'd0 : cur_mode + 3'd1;
            end else begin
              dwell_cnt <= dwell_cnt + DW'(1);
            end
          end
`endif
        end
        PEND: begin
          // Mode and ack take effect on the boundary edge itself; APPLY only retires busy.
          if (bnd) begin
            cur_mode <= req_mode;
            mode_ack <= 1'b1;
            state    <= APPLY;
`ifdef VGA_SEQ_AUTO_EN
            dwell_cnt <= '0;
`endif
          end
        end
        APPLY: begin
          mode_busy <= 1'b0;
          state     <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
